spi_reg_slave: RTL and testbench

- Parametrised SPI slave (mode 0, sampling on rising sclk) that fronts a DATA_W x 2**ADDR_W register file.
- Each frame is a command (R/W bit + address) followed by one or more data words. The address auto-increments with wrap for bursts.
- Replaces the single-byte, no-reset echo slave. Adds addressing, burst transfers, a write-notify strobe to local logic, and asynchronous reset.

---
 rtl/spi_reg_pkg.sv | 25 ++
 rtl/spi_shift_reg.sv | 55 +++++
 rtl/spi_reg_slave.sv | 213 +++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_pkg
// Purpose  : Shared FSM state type, command encodings and bit-order helper
//            for the SPI register-file slave.
// Revision : 1.0
// ============================================================================
package spi_reg_pkg;

    typedef enum logic [1:0] {
        CMD     = 2'd0,
        WR_DATA = 2'd1,
        RD_DATA = 2'd2
    } spi_state_t;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    // Register bit index of the n-th bit on the wire for the chosen bit order.
    function automatic int bit_idx(input bit msb_first, input int width, input int n);
        return msb_first ? (width - 1 - n) : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : spi_shift_reg
// Purpose  : DATA_W serial-in/serial-out shifter with clear, parallel load
//            and shift enable; bit order set by MSB_FIRST.
// Revision : 1.0
// ============================================================================
module spi_shift_reg
    import spi_reg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              shift_en_i,
    input  logic              ser_i,
    output logic [DATA_W-1:0] nxt_o,
    output logic              ser_o
);

    localparam int c_out_idx = bit_idx(MSB_FIRST, DATA_W, 0);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {sr_q[DATA_W-2:0], ser_i};
        end else begin : g_lsb_first
            assign w_shifted = {ser_i, sr_q[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else if (clr_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= load_data_i;
        end else if (shift_en_i) begin
            sr_q <= w_shifted;
        end
    end

    // nxt_o lets the receiver commit a word on the same edge as its last bit.
    assign nxt_o = w_shifted;
    assign ser_o = sr_q[c_out_idx];

endmodule
`default_nettype wire

// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_slave
// Purpose  : Mode-0 SPI slave fronting a 2**ADDR_W x DATA_W register file
//            with burst auto-increment and a write-notify strobe.
//            Define SPI_MISO_TRISTATE_EN to float miso while deselected.
// Revision : 1.0
// ============================================================================
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              ssel,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int c_depth       = 2 ** ADDR_W;
    localparam int c_cnt_max     = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int c_cnt_w       = $clog2(c_cnt_max + 1);
    localparam int c_addr_in_idx = bit_idx(MSB_FIRST, ADDR_W, ADDR_W - 1);

    localparam logic [c_cnt_w-1:0] c_cnt_addr_last = c_cnt_w'(ADDR_W);
    localparam logic [c_cnt_w-1:0] c_cnt_data_last = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one       = c_cnt_w'(1);
    localparam logic [ADDR_W-1:0]  c_addr_one      = ADDR_W'(1);

    spi_state_t         state_q,    state_d;
    logic [c_cnt_w-1:0] cnt_q,      cnt_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic               rw_q,       rw_d;
    logic               wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]  wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q,  wr_data_d;

    logic [DATA_W-1:0]  mem_q [c_depth];

    logic [ADDR_W-1:0]  w_addr_shift;
    logic [ADDR_W-1:0]  w_addr_inc;
    logic               w_mem_we;
    logic               w_rx_shift;
    logic [DATA_W-1:0]  w_rx_word;
    logic               w_rx_ser;
    logic               w_tx_load;
    logic               w_tx_shift;
    logic [DATA_W-1:0]  w_tx_load_data;
    logic [DATA_W-1:0]  w_tx_nxt;
    logic               w_tx_bit;
    logic               w_unused;

    // Address as it will look once the bit currently on mosi is shifted in.
    always_comb begin
        w_addr_shift                = MSB_FIRST ? (addr_q << 1) : (addr_q >> 1);
        w_addr_shift[c_addr_in_idx] = mosi;
    end

    assign w_addr_inc = addr_q + c_addr_one;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CMD;
            cnt_q      <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        rw_d           = rw_q;
        wr_valid_d     = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        w_mem_we       = 1'b0;
        w_rx_shift     = 1'b0;
        w_tx_load      = 1'b0;
        w_tx_shift     = 1'b0;
        w_tx_load_data = '0;

        if (ssel) begin
            state_d = CMD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CMD: begin
                    if (cnt_q == '0) begin
                        rw_d  = mosi;
                        cnt_d = c_cnt_one;
                    end else begin
                        addr_d = w_addr_shift;
                        if (cnt_q == c_cnt_addr_last) begin
                            cnt_d          = '0;
                            state_d        = (rw_q == CMD_WRITE) ? WR_DATA : RD_DATA;
                            w_tx_load      = (rw_q == CMD_READ);
                            w_tx_load_data = mem_q[w_addr_shift];
                        end else begin
                            cnt_d = cnt_q + c_cnt_one;
                        end
                    end
                end

                WR_DATA: begin
                    w_rx_shift = 1'b1;
                    if (cnt_q == c_cnt_data_last) begin
                        w_mem_we   = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = w_rx_word;
                        addr_d     = w_addr_inc;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end

                RD_DATA: begin
                    // Last bit of the word is already on miso; stage the next word.
                    if (cnt_q == c_cnt_data_last) begin
                        addr_d         = w_addr_inc;
                        w_tx_load      = 1'b1;
                        w_tx_load_data = mem_q[w_addr_inc];
                        cnt_d          = '0;
                    end else begin
                        w_tx_shift = 1'b1;
                        cnt_d      = cnt_q + c_cnt_one;
                    end
                end

                default: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_mem_we) begin
            mem_q[addr_q] <= w_rx_word;
        end
    end

    spi_shift_reg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx_shift (
        .clk_i       (sclk),
        .rst_ni      (rst_n),
        .clr_i       (ssel),
        .load_i      (1'b0),
        .load_data_i ({DATA_W{1'b0}}),
        .shift_en_i  (w_rx_shift),
        .ser_i       (mosi),
        .nxt_o       (w_rx_word),
        .ser_o       (w_rx_ser)
    );

    spi_shift_reg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx_shift (
        .clk_i       (sclk),
        .rst_ni      (rst_n),
        .clr_i       (ssel),
        .load_i      (w_tx_load),
        .load_data_i (w_tx_load_data),
        .shift_en_i  (w_tx_shift),
        .ser_i       (1'b0),
        .nxt_o       (w_tx_nxt),
        .ser_o       (w_tx_bit)
    );

    assign w_unused = ^{w_rx_ser, w_tx_nxt};

`ifdef SPI_MISO_TRISTATE_EN
    assign miso = ssel ? 1'bz : w_tx_bit;
`else
    assign miso = ssel ? 1'b0 : w_tx_bit;
`endif

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != CMD);

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_slave
// Purpose  : Directed self-checking bench for spi_reg_slave (8-bit data,
//            4-bit address, MSB first).
// Revision : 1.0
// ============================================================================
module tb_spi_reg_slave;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

`ifdef SPI_MISO_TRISTATE_EN
    localparam logic c_miso_idle = 1'bz;
`else
    localparam logic c_miso_idle = 1'b0;
`endif

    logic              sclk;
    logic              rst_n;
    logic              ssel;
    logic              mosi;
    logic              miso;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;
    int wv_total = 0;

    logic              s_miso, s_wv, s_busy;
    logic [ADDR_W-1:0] s_wa;
    logic [DATA_W-1:0] s_wd;
    logic              f_wv;
    logic [ADDR_W-1:0] f_wa;
    logic [DATA_W-1:0] f_wd;
    logic [DATA_W-1:0] rd;

    spi_reg_slave #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MSB_FIRST (1'b1)
    ) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .ssel     (ssel),
        .mosi     (mosi),
        .miso     (miso),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    always @(negedge sclk) begin
        if (wr_valid === 1'b1) wv_total++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic sample();
        s_miso = miso;
        s_wv   = wr_valid;
        s_wa   = wr_addr;
        s_wd   = wr_data;
        s_busy = busy;
    endtask

    task automatic bit_io(input logic b);
        @(negedge sclk);
        sample();
        ssel = 1'b0;
        mosi = b;
    endtask

    task automatic send_cmd(input logic rw, input logic [ADDR_W-1:0] a);
        bit_io(rw);
        for (int i = ADDR_W - 1; i >= 0; i--) bit_io(a[i]);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            bit_io(w[i]);
            if (i == DATA_W - 1) begin
                f_wv = s_wv;
                f_wa = s_wa;
                f_wd = s_wd;
            end
        end
    endtask

    task automatic recv_word(output logic [DATA_W-1:0] w);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            bit_io(1'b0);
            w[i] = s_miso;
        end
    endtask

    task automatic end_frame();
        @(negedge sclk);
        sample();
        ssel = 1'b1;
        mosi = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge sclk);
            sample();
            check("idle_miso", 32'(s_miso), 32'(c_miso_idle));
        end
    endtask

    task automatic read_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        send_cmd(1'b0, a);
        recv_word(rd);
        check($sformatf("rd@%0d", a), 32'(rd), 32'(exp));
        check("rd_busy", 32'(s_busy), 32'd1);
        end_frame();
        gap(2);
        check("rd_busy_end", 32'(s_busy), 32'd0);
    endtask

    task automatic write_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        send_cmd(1'b1, a);
        send_word(w);
        check("wv_early", 32'(s_wv), 32'd0);
        end_frame();
        check("wv", 32'(s_wv), 32'd1);
        check("wa", 32'(s_wa), 32'(a));
        check("wd", 32'(s_wd), 32'(w));
        gap(2);
        check("wv_late", 32'(s_wv), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        ssel  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge sclk);
        check("rst_wv",   32'(wr_valid), 32'd0);
        check("rst_wa",   32'(wr_addr),  32'd0);
        check("rst_wd",   32'(wr_data),  32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_miso", 32'(miso),     32'(c_miso_idle));
        rst_n = 1'b1;
        gap(2);

        // Cleared register reads back zero; no strobe on reads.
        read_frame(4'd3, 8'h00);
        check("wv_total_0", 32'(wv_total), 32'd0);

        write_frame(4'd3, 8'hA5);
        check("wv_total_1", 32'(wv_total), 32'd1);
        read_frame(4'd3, 8'hA5);

        // Burst write across the address wrap.
        send_cmd(1'b1, 4'd15);
        send_word(8'h11);
        send_word(8'h22);
        check("b_wv1", 32'(f_wv), 32'd1);
        check("b_wa1", 32'(f_wa), 32'd15);
        check("b_wd1", 32'(f_wd), 32'h11);
        end_frame();
        check("b_wv2", 32'(s_wv), 32'd1);
        check("b_wa2", 32'(s_wa), 32'd0);
        check("b_wd2", 32'(s_wd), 32'h22);
        gap(2);
        check("wv_total_3", 32'(wv_total), 32'd3);

        send_cmd(1'b0, 4'd15);
        recv_word(rd);
        check("brd0", 32'(rd), 32'h11);
        recv_word(rd);
        check("brd1", 32'(rd), 32'h22);
        end_frame();
        gap(2);

        // Abort a write after four data bits.
        send_cmd(1'b1, 4'd5);
        repeat (4) bit_io(1'b1);
        end_frame();
        check("ab_busy_in", 32'(s_busy), 32'd1);
        gap(1);
        check("ab_busy_out", 32'(s_busy), 32'd0);
        gap(1);
        check("ab_wv_total", 32'(wv_total), 32'd3);
        read_frame(4'd5, 8'h00);
        write_frame(4'd5, 8'h3C);
        read_frame(4'd5, 8'h3C);
        check("wv_total_4", 32'(wv_total), 32'd4);

        // Reset while the strobe is up and the second burst word is in flight.
        send_cmd(1'b1, 4'd7);
        send_word(8'h5A);
        bit_io(1'b1);
        check("mr_wv", 32'(s_wv), 32'd1);
        check("mr_wa", 32'(s_wa), 32'd7);
        check("mr_wd", 32'(s_wd), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        check("mr_rst_wv",   32'(wr_valid), 32'd0);
        check("mr_rst_wa",   32'(wr_addr),  32'd0);
        check("mr_rst_wd",   32'(wr_data),  32'd0);
        check("mr_rst_busy", 32'(busy),     32'd0);
        check("mr_rst_miso", 32'(miso),     32'd0);
        @(negedge sclk);
        ssel = 1'b1;
        mosi = 1'b0;
        @(negedge sclk);
        rst_n = 1'b1;
        gap(2);
        read_frame(4'd3, 8'h00);
        read_frame(4'd7, 8'h00);
        read_frame(4'd15, 8'h00);
        write_frame(4'd9, 8'hC3);
        read_frame(4'd9, 8'hC3);
        check("wv_total_6", 32'(wv_total), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
